title_anim_ctrl: RTL and testbench

TITLE_ANIM_CTRL -- requirements
Module: title_anim_ctrl

---
 rtl/title_anim_ctrl.sv | 163 ++++++++++++++++
 tb/tb_title_anim_ctrl.sv | 423 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/title_anim_ctrl.sv
// Title animation controller.
// Tracks the frame boundary on the video timing counters and runs a small
// STATIC/SCROLL/BLINK state machine. It moves the title x-origin back and
// forth, or blinks the title. The renderer-facing outputs only change on
// frame_tick, so the renderer never sees a torn title.
// Optional feature macro: TITLE_COLOR_ROT_EN. When defined, color_rot
// advances on every animation step. When undefined, color_rot is tied to 0.
//
// state      | meaning
// -----------+------------------------------------------------------------
// ST_STATIC  | title parked at X_HOME, always visible, no steps
// ST_SCROLL  | x_base bounces between X_MIN and X_MAX, STEP px per step
// ST_BLINK   | x_base held, title_vis toggles on every step
module title_anim_ctrl #(
    parameter int X_HOME      = 320,
    parameter int X_MIN       = 0,
    parameter int X_MAX       = 500,
    parameter int STEP        = 4,
    parameter int FRAME_DIV   = 4,
    parameter int COMMIT_LINE = 600
) (
    input  logic        PixelClk,
    input  logic        RST,
    input  logic [15:0] PixelCount,
    input  logic [15:0] LineCount,
    input  logic        anim_en,
    input  logic        mode_req_valid,
    input  logic [1:0]  mode_req,
    output logic        mode_req_ready,
    output logic [15:0] x_base,
    output logic [2:0]  color_rot,
    output logic        title_vis,
    output logic        frame_tick
);

    localparam logic [1:0]  ST_STATIC  = 2'd0;
    localparam logic [1:0]  ST_SCROLL  = 2'd1;
    localparam logic [1:0]  ST_BLINK   = 2'd2;
    localparam logic [1:0]  MODE_RSVD  = 2'd3;

    localparam logic [15:0] X_HOME_V   = 16'(X_HOME);
    localparam logic [15:0] X_MIN_V    = 16'(X_MIN);
    localparam logic [15:0] X_MAX_V    = 16'(X_MAX);
    localparam logic [15:0] X_STEP_V   = 16'(STEP);
    localparam logic [16:0] X_MIN_W    = 17'(X_MIN);
    localparam logic [16:0] X_MAX_W    = 17'(X_MAX);
    localparam logic [16:0] X_STEP_W   = 17'(STEP);
    localparam logic [7:0]  FDIV_LAST  = 8'(FRAME_DIV - 1);
    localparam logic [15:0] COMMIT_V   = 16'(COMMIT_LINE);

    logic [1:0]  state;
    logic        dir_left;
    logic [7:0]  frame_cnt;
    logic        pending;
    logic [1:0]  pend_mode;
    logic        boundary;
    logic        commit;
    logic [15:0] x_next;
    logic        dir_next;

    assign boundary       = (PixelCount == 16'd0) && (LineCount == COMMIT_V);
    assign commit         = frame_tick && pending;
    assign mode_req_ready = ~pending;

    // Register the boundary detect so frame_tick is a clean one-cycle pulse.
    always_ff @(posedge PixelClk) begin
        if (RST) begin
            frame_tick <= 1'b0;
        end else begin
            frame_tick <= boundary;
        end
    end

    // Mode-change handshake: hold one request until the next frame boundary.
    always_ff @(posedge PixelClk) begin
        if (RST) begin
            pending   <= 1'b0;
            pend_mode <= ST_STATIC;
        end else if (commit) begin
            pending <= 1'b0;
        end else if (mode_req_valid && !pending) begin
            pending   <= 1'b1;
            pend_mode <= mode_req;
        end
    end

    // Next scroll position; the compares run in 17 bits so nothing wraps
    // past 0 or 0xFFFF.
    always_comb begin
        x_next   = x_base;
        dir_next = dir_left;
        if (!dir_left) begin
            if (({1'b0, x_base} + X_STEP_W) >= X_MAX_W) begin
                x_next   = X_MAX_V;
                dir_next = 1'b1;
            end else begin
                x_next = x_base + X_STEP_V;
            end
        end else begin
            if ({1'b0, x_base} <= (X_MIN_W + X_STEP_W)) begin
                x_next   = X_MIN_V;
                dir_next = 1'b0;
            end else begin
                x_next = x_base - X_STEP_V;
            end
        end
    end

    // Mode commit and animation stepping, evaluated only on frame_tick.
    always_ff @(posedge PixelClk) begin
        if (RST) begin
            state     <= ST_STATIC;
            x_base    <= X_HOME_V;
            dir_left  <= 1'b0;
            title_vis <= 1'b1;
            frame_cnt <= 8'd0;
        end else if (commit) begin
            if (pend_mode != MODE_RSVD) begin
                state     <= pend_mode;
                frame_cnt <= 8'd0;
                title_vis <= 1'b1;
                if (pend_mode == ST_STATIC) begin
                    x_base <= X_HOME_V;
                end
            end
        end else if (frame_tick) begin
            if (!anim_en) begin
                title_vis <= 1'b1;
            end else if (state != ST_STATIC) begin
                if (frame_cnt == FDIV_LAST) begin
                    frame_cnt <= 8'd0;
                    if (state == ST_SCROLL) begin
                        x_base   <= x_next;
                        dir_left <= dir_next;
                    end else if (state == ST_BLINK) begin
                        title_vis <= ~title_vis;
                    end
                end else begin
                    frame_cnt <= frame_cnt + 8'd1;
                end
            end
        end
    end

`ifdef TITLE_COLOR_ROT_EN
    logic step;

    assign step = frame_tick && !pending && anim_en && (state != ST_STATIC)
                  && (frame_cnt == FDIV_LAST);

    // Per-character color rotation, advancing 0..4 on every animation step.
    always_ff @(posedge PixelClk) begin
        if (RST) begin
            color_rot <= 3'd0;
        end else if (step) begin
            color_rot <= (color_rot == 3'd4) ? 3'd0 : color_rot + 3'd1;
        end
    end
`else
    assign color_rot = 3'd0;
`endif

endmodule

// File: tb/tb_title_anim_ctrl.sv
// Self-checking bench for title_anim_ctrl.
// It uses a tiny 4x4 video raster (boundary at line 3) so that frames are
// short. A frame-level reference model predicts every output on every cycle.
module tb_title_anim_ctrl;

    localparam int X_HOME      = 320;
    localparam int X_MIN       = 0;
    localparam int X_MAX       = 500;
    localparam int STEP        = 4;
    localparam int FRAME_DIV   = 4;
    localparam int COMMIT_LINE = 3;
    localparam int H_TOTAL     = 4;
    localparam int V_TOTAL     = 4;
    localparam int FRAME_CYC   = H_TOTAL * V_TOTAL;

    logic        PixelClk = 1'b0;
    logic        RST;
    logic [15:0] PixelCount;
    logic [15:0] LineCount;
    logic        anim_en;
    logic        mode_req_valid;
    logic [1:0]  mode_req;
    logic        mode_req_ready;
    logic [15:0] x_base;
    logic [2:0]  color_rot;
    logic        title_vis;
    logic        frame_tick;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model state (frame-level view of the title)
    int m_x, m_rot, m_mode, m_ticks, m_pend_val;
    bit m_left, m_vis, m_pend, m_tick;
    int tick_edges  = 0;
    int mism_cycles = 0;
    int dut_ticks   = 0;

    title_anim_ctrl #(
        .X_HOME(X_HOME), .X_MIN(X_MIN), .X_MAX(X_MAX), .STEP(STEP),
        .FRAME_DIV(FRAME_DIV), .COMMIT_LINE(COMMIT_LINE)
    ) dut (
        .PixelClk(PixelClk), .RST(RST), .PixelCount(PixelCount), .LineCount(LineCount),
        .anim_en(anim_en), .mode_req_valid(mode_req_valid), .mode_req(mode_req),
        .mode_req_ready(mode_req_ready), .x_base(x_base), .color_rot(color_rot),
        .title_vis(title_vis), .frame_tick(frame_tick)
    );

    always #5 PixelClk = ~PixelClk;

    function automatic void model_reset();
        m_x = X_HOME; m_left = 0; m_rot = 0; m_vis = 1; m_mode = 0;
        m_ticks = 0; m_pend = 0; m_pend_val = 0; m_tick = 0;
    endfunction

    function automatic void model_step();
        if (m_mode == 1) begin
            if (!m_left) begin
                m_x = (m_x + STEP < X_MAX) ? m_x + STEP : X_MAX;
                if (m_x == X_MAX) m_left = 1;
            end else begin
                m_x = (m_x - STEP > X_MIN) ? m_x - STEP : X_MIN;
                if (m_x == X_MIN) m_left = 0;
            end
        end else begin
            m_vis = !m_vis;
        end
`ifdef TITLE_COLOR_ROT_EN
        m_rot = (m_rot + 1) % 5;
`endif
    endfunction

    // What happens to the title at one frame boundary.
    function automatic void model_frame();
        if (m_pend) begin
            m_pend = 0;
            if (m_pend_val != 3) begin
                m_mode = m_pend_val; m_ticks = 0; m_vis = 1;
                if (m_mode == 0) m_x = X_HOME;
            end
        end else if (!anim_en) begin
            m_vis = 1;
        end else if (m_mode != 0) begin
            m_ticks++;
            if (m_ticks == FRAME_DIV) begin
                m_ticks = 0;
                model_step();
            end
        end
    endfunction

    function automatic void model_edge();
        bit acc;
        if (RST) begin
            model_reset();
            return;
        end
        acc = mode_req_valid && !m_pend;
        if (m_tick) begin
            tick_edges++;
            model_frame();
        end
        if (acc) begin
            m_pend = 1; m_pend_val = int'(mode_req);
        end
        m_tick = (PixelCount == 16'd0) && (LineCount == 16'(COMMIT_LINE));
    endfunction

    // One clock: update the model, compare every output, then advance the raster.
    task automatic cyc();
        @(posedge PixelClk);
        #1;
        model_edge();
        if (frame_tick === 1'b1) dut_ticks++;
        if (x_base !== 16'(m_x) || color_rot !== 3'(m_rot) || title_vis !== m_vis ||
            frame_tick !== m_tick || mode_req_ready !== !m_pend)
            mism_cycles++;
        if (PixelCount == 16'(H_TOTAL - 1)) begin
            PixelCount = 16'd0;
            LineCount  = (LineCount == 16'(V_TOTAL - 1)) ? 16'd0 : LineCount + 16'd1;
        end else begin
            PixelCount = PixelCount + 16'd1;
        end
    endtask

    task automatic run_frames(input int n);
        for (int i = 0; i < n * FRAME_CYC; i++) cyc();
    endtask

    task automatic wait_ticks(input int n, input string tag);
        int target;
        int budget;
        target = tick_edges + n;
        budget = (n + 2) * FRAME_CYC;
        while (tick_edges < target && budget > 0) begin
            cyc();
            budget--;
        end
        n_checks++;
        if (tick_edges < target) begin
            n_fail++;
            $display("FAIL %s_tick_timeout: saw %0d ticks, required %0d", tag, tick_edges, target);
        end
    endtask

    task automatic wait_commit(input string tag);
        int budget;
        budget = 3 * FRAME_CYC;
        while (m_pend && budget > 0) begin
            cyc();
            budget--;
        end
        n_checks++;
        if (m_pend) begin
            n_fail++;
            $display("FAIL %s_commit_timeout: request still pending after %0d cycles", tag, 3 * FRAME_CYC);
        end
    endtask

    task automatic wait_x(input int target, input string tag);
        int budget;
        budget = 20000;
        while (m_x != target && budget > 0) begin
            cyc();
            budget--;
        end
        n_checks++;
        if (m_x != target) begin
            n_fail++;
            $display("FAIL %s_x_timeout: model x %0d never reached %0d", tag, m_x, target);
        end
    endtask

    task automatic send_req(input logic [1:0] v, input string tag);
        bit pre;
        bit acc;
        acc = 0;
        mode_req_valid = 1'b1;
        mode_req = v;
        for (int i = 0; i < 4 * FRAME_CYC; i++) begin
            pre = !m_pend;
            cyc();
            if (pre) begin
                acc = 1;
                break;
            end
        end
        mode_req_valid = 1'b0;
        n_checks++;
        if (!acc) begin
            n_fail++;
            $display("FAIL %s_accept: request %0d never accepted", tag, v);
        end
    endtask

    task automatic check_mism(input string tag);
        n_checks++;
        if (mism_cycles !== 0) begin
            n_fail++;
            $display("FAIL %s_trace: %0d cycles differ from model, required 0", tag, mism_cycles);
        end
        mism_cycles = 0;
    endtask

    task automatic test_reset();
        RST = 1'b1; anim_en = 1'b1; mode_req_valid = 1'b0; mode_req = 2'd0;
        PixelCount = 16'd0; LineCount = 16'd0;
        repeat (3) cyc();
        n_checks += 5;
        if (x_base !== 16'd320) begin n_fail++; $display("FAIL reset_x: got %0d want 320", x_base); end
        if (title_vis !== 1'b1) begin n_fail++; $display("FAIL reset_vis: got %b want 1", title_vis); end
        if (color_rot !== 3'd0) begin n_fail++; $display("FAIL reset_rot: got %0d want 0", color_rot); end
        if (mode_req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", mode_req_ready); end
        if (frame_tick !== 1'b0) begin n_fail++; $display("FAIL reset_tick: got %b want 0", frame_tick); end
        RST = 1'b0;
        mism_cycles = 0;
    endtask

    task automatic test_idle();
        dut_ticks = 0;
        run_frames(3);
        n_checks += 3;
        if (dut_ticks !== 3) begin n_fail++; $display("FAIL idle_ticks: got %0d want 3", dut_ticks); end
        if (x_base !== 16'd320) begin n_fail++; $display("FAIL idle_x: got %0d want 320", x_base); end
        if (mode_req_ready !== 1'b1) begin n_fail++; $display("FAIL idle_ready: got %b want 1", mode_req_ready); end
        check_mism("idle");
    endtask

    task automatic test_scroll();
        logic [2:0] r1, r2;
`ifdef TITLE_COLOR_ROT_EN
        r1 = 3'd1; r2 = 3'd2;
`else
        r1 = 3'd0; r2 = 3'd0;
`endif
        send_req(2'd1, "scroll");
        n_checks++;
        if (mode_req_ready !== 1'b0) begin n_fail++; $display("FAIL scroll_ready_low: got %b want 0", mode_req_ready); end
        wait_commit("scroll");
        n_checks += 2;
        if (x_base !== 16'd320) begin n_fail++; $display("FAIL scroll_commit_x: got %0d want 320", x_base); end
        if (mode_req_ready !== 1'b1) begin n_fail++; $display("FAIL scroll_ready_back: got %b want 1", mode_req_ready); end
        wait_ticks(4, "scroll1");
        n_checks += 2;
        if (x_base !== 16'd324) begin n_fail++; $display("FAIL scroll_step1_x: got %0d want 324", x_base); end
        if (color_rot !== r1) begin n_fail++; $display("FAIL scroll_step1_rot: got %0d want %0d", color_rot, r1); end
        wait_ticks(4, "scroll2");
        n_checks += 2;
        if (x_base !== 16'd328) begin n_fail++; $display("FAIL scroll_step2_x: got %0d want 328", x_base); end
        if (color_rot !== r2) begin n_fail++; $display("FAIL scroll_step2_rot: got %0d want %0d", color_rot, r2); end
        check_mism("scroll");
    endtask

    task automatic test_pending_blink();
        int low_dut;
        int low_exp;
        bit pre;
        bit acc;
        low_dut = 0; low_exp = 0; acc = 0;
        send_req(2'd1, "pend_scroll");
        mode_req_valid = 1'b1;
        mode_req = 2'd2;
        for (int i = 0; i < 4 * FRAME_CYC; i++) begin
            pre = !m_pend;
            if (!pre) low_exp++;
            if (mode_req_ready === 1'b0) low_dut++;
            cyc();
            if (pre) begin
                acc = 1;
                break;
            end
        end
        mode_req_valid = 1'b0;
        n_checks += 2;
        if (!acc) begin n_fail++; $display("FAIL blink_accept: BLINK request never accepted"); end
        if (low_dut !== low_exp) begin n_fail++; $display("FAIL blink_ready_held: low cycles %0d want %0d", low_dut, low_exp); end
        wait_commit("blink");
        n_checks++;
        if (title_vis !== 1'b1) begin n_fail++; $display("FAIL blink_commit_vis: got %b want 1", title_vis); end
        wait_ticks(4, "blink1");
        n_checks++;
        if (title_vis !== 1'b0) begin n_fail++; $display("FAIL blink_toggle1: got %b want 0", title_vis); end
        wait_ticks(4, "blink2");
        n_checks++;
        if (title_vis !== 1'b1) begin n_fail++; $display("FAIL blink_toggle2: got %b want 1", title_vis); end
        check_mism("blink");
    endtask

    task automatic test_accept_on_tick();
        int budget;
        budget = 2 * FRAME_CYC;
        while (!(m_tick && !m_pend) && budget > 0) begin
            cyc();
            budget--;
        end
        mode_req_valid = 1'b1;
        mode_req = 2'd1;
        cyc();
        mode_req_valid = 1'b0;
        n_checks++;
        if (mode_req_ready !== 1'b0) begin n_fail++; $display("FAIL tick_accept_pending: ready %b want 0", mode_req_ready); end
        wait_ticks(1, "tick_accept");
        n_checks += 2;
        if (mode_req_ready !== 1'b1) begin n_fail++; $display("FAIL tick_accept_commit: ready %b want 1", mode_req_ready); end
        if (title_vis !== 1'b1) begin n_fail++; $display("FAIL tick_accept_vis: got %b want 1", title_vis); end
        check_mism("tick_accept");
    endtask

    task automatic test_boundary();
        wait_x(X_MAX, "right_edge");
        n_checks++;
        if (x_base !== 16'd500) begin n_fail++; $display("FAIL edge_max: got %0d want 500", x_base); end
        wait_ticks(FRAME_DIV, "after_max");
        n_checks++;
        if (x_base !== 16'd496) begin n_fail++; $display("FAIL edge_max_turn: got %0d want 496", x_base); end
        wait_x(X_MIN, "left_edge");
        n_checks++;
        if (x_base !== 16'd0) begin n_fail++; $display("FAIL edge_min: got %0d want 0", x_base); end
        wait_ticks(FRAME_DIV, "after_min");
        n_checks++;
        if (x_base !== 16'd4) begin n_fail++; $display("FAIL edge_min_turn: got %0d want 4", x_base); end
        check_mism("boundary");
    endtask

    task automatic test_freeze();
        int bad_x;
        int bad_vis;
        bad_x = 0; bad_vis = 0;
        wait_x(400, "freeze_reach");
        anim_en = 1'b0;
        for (int i = 0; i < 10 * FRAME_CYC; i++) begin
            cyc();
            if (x_base !== 16'd400) bad_x++;
            if (title_vis !== 1'b1) bad_vis++;
        end
        n_checks += 2;
        if (bad_x !== 0) begin n_fail++; $display("FAIL freeze_x: %0d cycles off 400, want 0", bad_x); end
        if (bad_vis !== 0) begin n_fail++; $display("FAIL freeze_vis: %0d cycles hidden, want 0", bad_vis); end
        send_req(2'd0, "freeze_static");
        wait_commit("freeze_static");
        n_checks += 2;
        if (x_base !== 16'd320) begin n_fail++; $display("FAIL freeze_static_x: got %0d want 320", x_base); end
        if (title_vis !== 1'b1) begin n_fail++; $display("FAIL freeze_static_vis: got %b want 1", title_vis); end
        anim_en = 1'b1;
        check_mism("freeze");
    endtask

    task automatic test_reserved();
        send_req(2'd3, "reserved");
        wait_commit("reserved");
        run_frames(8);
        n_checks += 3;
        if (x_base !== 16'd320) begin n_fail++; $display("FAIL reserved_x: got %0d want 320", x_base); end
        if (title_vis !== 1'b1) begin n_fail++; $display("FAIL reserved_vis: got %b want 1", title_vis); end
        if (mode_req_ready !== 1'b1) begin n_fail++; $display("FAIL reserved_ready: got %b want 1", mode_req_ready); end
        check_mism("reserved");
    endtask

    task automatic test_reset_mid();
        int budget;
        budget = 2 * FRAME_CYC;
        while (!(PixelCount == 16'(H_TOTAL - 1) && LineCount == 16'(COMMIT_LINE - 1)) && budget > 0) begin
            cyc();
            budget--;
        end
        mode_req_valid = 1'b1;
        mode_req = 2'd2;
        cyc();
        mode_req_valid = 1'b0;
        RST = 1'b1;
        cyc();
        RST = 1'b0;
        n_checks += 2;
        if (mode_req_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_ready: got %b want 1", mode_req_ready); end
        if (frame_tick !== 1'b0) begin n_fail++; $display("FAIL rstmid_tick: got %b want 0", frame_tick); end
        dut_ticks = 0;
        repeat (10) cyc();
        n_checks++;
        if (dut_ticks !== 0) begin n_fail++; $display("FAIL rstmid_no_tick: got %0d ticks want 0", dut_ticks); end
        run_frames(6);
        n_checks++;
        if (title_vis !== 1'b1) begin n_fail++; $display("FAIL rstmid_vis: got %b want 1", title_vis); end
        check_mism("reset_mid");
    endtask

    task automatic test_random();
        int exp_ticks;
        exp_ticks = tick_edges;
        dut_ticks = 0;
        for (int i = 0; i < 3000; i++) begin
            mode_req_valid = ($urandom_range(0, 7) == 0);
            mode_req       = 2'($urandom_range(0, 3));
            anim_en        = ($urandom_range(0, 9) != 0);
            RST            = ($urandom_range(0, 599) == 0);
            cyc();
            if (RST) begin
                RST = 1'b0;
            end
        end
        mode_req_valid = 1'b0;
        cyc();
        n_checks++;
        if (dut_ticks < 100) begin n_fail++; $display("FAIL random_tick_rate: got %0d ticks want at least 100", dut_ticks); end
        check_mism("random");
        exp_ticks = tick_edges - exp_ticks;
    endtask

    initial begin
        test_reset();
        test_idle();
        test_scroll();
        test_pending_blink();
        test_accept_on_tick();
        test_boundary();
        test_freeze();
        test_reserved();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
